// File: rtl/rom_if_pkg.sv
// Shared widths, read latency and burst-reader FSM states for the ROM
// read interface.
package rom_if_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;
    localparam int ROM_LAT    = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } rd_state_e;

endpackage

// File: rtl/rom_rd_fifo.sv
// Small synchronous FIFO whose head entry is held in a register, so rd_data
// is a flop output and stays stable until the entry is popped.
module rom_rd_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int DATA_W     = 8
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          wr_en,
    input  logic [DATA_W-1:0]             wr_data,
    input  logic                          rd_en,
    output logic [DATA_W-1:0]             rd_data,
    output logic [$clog2(FIFO_DEPTH):0]   count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, rd_nxt;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic              rd_ok, wr_ok;

    always_comb begin
        rd_ok   = rd_en && (count_q != '0);
        wr_ok   = wr_en && ((count_q != CNT_W'(FIFO_DEPTH)) || rd_ok);
        rd_nxt  = PTR_W'(rd_ptr_q + 1'b1);
        count_d = count_q + {{(CNT_W-1){1'b0}}, wr_ok} - {{(CNT_W-1){1'b0}}, rd_ok};
        head_d  = head_q;
        // The head register mirrors mem_q[rd_ptr_q]; a single remaining
        // entry being popped while a write lands hands over to wr_data.
        if (rd_ok) begin
            if (count_q == CNT_W'(1)) begin
                if (wr_ok) head_d = wr_data;
            end else begin
                head_d = mem_q[rd_nxt];
            end
        end else if ((count_q == '0) && wr_ok) begin
            head_d = wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            if (wr_ok) wr_ptr_q <= PTR_W'(wr_ptr_q + 1'b1);
            if (rd_ok) rd_ptr_q <= rd_nxt;
            count_q <= count_d;
            head_q  <= head_d;
        end
    end

    assign rd_data = head_q;
    assign count   = count_q;

endmodule

// File: rtl/rom_burst_reader.sv
// Sweeps a contiguous ROM address range, buffers returned bytes and streams
// them out with a last flag and a running 8-bit checksum.
module rom_burst_reader
    import rom_if_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic              rom_ce,
    output logic              rom_ren,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic [DATA_W-1:0] checksum
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    rd_state_e         state_q, state_d;
    logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   issued_q, issued_d;
    logic [ADDR_W:0]   xfer_q, xfer_d, xfer_inc;
    logic [DATA_W-1:0] ck_q, ck_d;
    logic              rom_ce_q, rom_ce_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic              rd_pend_q;
    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W:0]    inflight;
    logic              issue, xfer, last_beat;

    rom_rd_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (rd_pend_q),
        .wr_data (rom_data),
        .rd_en   (xfer),
        .rd_data (out_data),
        .count   (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign xfer      = out_valid && out_ready;
    assign xfer_inc  = xfer_q + 1'b1;
    assign last_beat = (xfer_inc == len_q);
    assign out_last  = out_valid && last_beat;

    // Credit counts buffered bytes plus reads still travelling through the
    // ROM, so every returned byte is guaranteed a FIFO slot.
    assign inflight = {1'b0, fifo_count} + {{CNT_W{1'b0}}, rom_ce_q}
                    + {{CNT_W{1'b0}}, rd_pend_q};
    assign issue    = (state_q == ST_READ) && (issued_q < len_q)
                    && (inflight < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        state_d    = state_q;
        cur_addr_d = cur_addr_q;
        len_d      = len_q;
        issued_d   = issued_q;
        xfer_d     = xfer_q;
        ck_d       = ck_q;
        rom_ce_d   = 1'b0;
        rom_addr_d = rom_addr_q;

        if (xfer) begin
            xfer_d = xfer_inc;
            ck_d   = ck_q + out_data;
        end

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    len_d      = len;
                    cur_addr_d = start_addr;
                    issued_d   = '0;
                    xfer_d     = '0;
                    ck_d       = '0;
                    state_d    = (len == '0) ? ST_DONE : ST_READ;
                end
            end
            ST_READ: begin
                if (issue) begin
                    rom_ce_d   = 1'b1;
                    rom_addr_d = cur_addr_q;
                    cur_addr_d = cur_addr_q + 1'b1;
                    issued_d   = issued_q + 1'b1;
                    if ((issued_q + 1'b1) == len_q) state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (xfer && last_beat) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            cur_addr_q <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            xfer_q     <= '0;
            ck_q       <= '0;
            rom_ce_q   <= 1'b0;
            rom_addr_q <= '0;
            rd_pend_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            len_q      <= len_d;
            issued_q   <= issued_d;
            xfer_q     <= xfer_d;
            ck_q       <= ck_d;
            rom_ce_q   <= rom_ce_d;
            rom_addr_q <= rom_addr_d;
            // One-cycle ROM: a read driven this cycle returns data next cycle.
            rd_pend_q  <= rom_ce_q;
        end
    end

    assign rom_ce   = rom_ce_q;
    assign rom_ren  = rom_ce_q;
    assign rom_addr = rom_addr_q;
    assign busy     = (state_q == ST_READ) || (state_q == ST_DRAIN);
    assign done     = (state_q == ST_DONE);
    assign checksum = ck_q;

endmodule

// File: tb/tb_rom_burst_reader.sv
// Scoreboard bench for rom_burst_reader against a mem[i]=i synchronous ROM.
module tb_rom_burst_reader;

    logic       clk = 1'b0;
    logic       resetn, start, out_ready;
    logic [7:0] start_addr;
    logic [8:0] len;
    logic       busy, done, rom_ce, rom_ren, out_valid, out_last;
    logic [7:0] rom_addr, out_data, checksum;
    logic [7:0] rom_data = 8'h00;
    logic [7:0] mem [256];

    int  nvec = 0, nerr = 0, ntx = 0;
    bit  tog = 1'b0;

    logic [7:0] q_data [$];
    bit         q_last [$];
    logic [7:0] q_addr [$];

    rom_burst_reader dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .start_addr (start_addr),
        .len        (len),
        .busy       (busy),
        .done       (done),
        .rom_ce     (rom_ce),
        .rom_ren    (rom_ren),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .checksum   (checksum)
    );

    always #5 clk = ~clk;

    initial for (int i = 0; i < 256; i++) mem[i] = 8'(i);

    always @(posedge clk) if (rom_ce && rom_ren) rom_data <= mem[rom_addr];

    always @(posedge clk) if (tog) begin #1 out_ready = ~out_ready; end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        nvec++;
        if (obs !== want) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic push_exp(input logic [7:0] a, input int n);
        for (int i = 0; i < n; i++) begin
            q_data.push_back(a + 8'(i));
            q_last.push_back(i == n - 1);
            q_addr.push_back(a + 8'(i));
        end
    endtask

    // Returns one ns after the edge that accepts the start.
    task automatic kick(input logic [7:0] a, input logic [8:0] n);
        @(posedge clk);
        #1 start_addr = a; len = n; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns at the negedge where done is seen (or the budget runs out).
    task automatic wait_done(input int budget, input logic [7:0] ck);
        int n = 0;
        while (n < budget) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        chk("checksum", checksum, ck);
        chk("sb_empty", q_data.size() + q_addr.size(), 0);
    endtask

    bit         prev_last = 1'b0, prev_stall = 1'b0;
    logic [9:0] prev_out = '0;

    always @(negedge clk) begin
        if (!resetn) begin
            prev_last  = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (rom_ce) begin
                chk("rom_ren", rom_ren, 1);
                if (q_addr.size() == 0) chk("spurious_rd", 1, 0);
                else chk("rom_addr", rom_addr, q_addr.pop_front());
            end
            if (prev_last) chk("done_after_last", done, 1);
            if (prev_stall) chk("stall_hold", {out_valid, out_last, out_data}, prev_out);
            if (out_valid && out_ready) begin
                if (q_data.size() == 0) chk("spurious_out", 1, 0);
                else begin
                    chk("out_data", out_data, q_data.pop_front());
                    chk("out_last", out_last, q_last.pop_front());
                end
                ntx++;
            end
            prev_last  = out_valid && out_ready && out_last;
            prev_stall = out_valid && !out_ready;
            prev_out   = {out_valid, out_last, out_data};
        end
    end

    initial begin
        int nrd, base, n;
        resetn = 1'b0; start = 1'b0; out_ready = 1'b1;
        start_addr = '0; len = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rom_ce", rom_ce, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_checksum", checksum, 0);
        @(negedge clk) resetn = 1'b1;

        // 1: basic burst with latency and back-to-back reads
        push_exp(8'h10, 4);
        kick(8'h10, 9'd4);
        for (int k = 0; k <= 5; k++) begin
            @(negedge clk);
            if (k == 0) chk("t1_busy", busy, 1);
            chk("t1_rom_ce", rom_ce, (k >= 1 && k <= 4) ? 1 : 0);
            if (k == 2) chk("t1_valid_early", out_valid, 0);
            if (k == 3) begin
                chk("t1_valid", out_valid, 1);
                chk("t1_first", out_data, 8'h10);
            end
        end
        wait_done(30, 8'h46);
        @(negedge clk);
        chk("t1_done_pulse", done, 0);

        // 2: address wrap
        push_exp(8'hFE, 4);
        kick(8'hFE, 9'd4);
        wait_done(30, 8'hFE);

        // 3: backpressure limits reads to the buffer depth
        out_ready = 1'b0;
        push_exp(8'h00, 8);
        kick(8'h00, 9'd8);
        nrd = 0;
        repeat (12) begin
            @(negedge clk);
            nrd += int'(rom_ce);
        end
        chk("bp_reads", nrd, 4);
        chk("bp_valid", out_valid, 1);
        chk("bp_data", out_data, 8'h00);
        out_ready = 1'b1;
        wait_done(40, 8'h1C);

        // 4: full 256-byte sweep with toggling ready
        base = ntx;
        tog = 1'b1;
        push_exp(8'h80, 256);
        kick(8'h80, 9'd256);
        wait_done(1200, 8'h80);
        tog = 1'b0;
        out_ready = 1'b1;
        chk("sweep_cnt", ntx - base, 256);

        // 5: zero length, then ignored starts while busy and in DONE
        kick(8'h33, 9'd0);
        @(negedge clk);
        chk("z_busy", busy, 0);
        chk("z_done", done, 1);
        chk("z_checksum", checksum, 0);
        @(negedge clk);
        chk("z_done_pulse", done, 0);

        push_exp(8'h40, 6);
        kick(8'h40, 9'd6);
        @(posedge clk);
        #1 start_addr = 8'h99; len = 9'd3; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(40, 8'h8F);
        start_addr = 8'h55; len = 9'd5; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("done_start_ign", busy, 0);
        end

        // 6: reset in the middle of a burst
        push_exp(8'h00, 16);
        kick(8'h00, 9'd16);
        base = ntx;
        n = 0;
        while ((ntx - base) < 3 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("pre_rst_tx", ntx - base, 3);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_rom_ce", rom_ce, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_checksum", checksum, 0);
        q_data.delete();
        q_last.delete();
        q_addr.delete();
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        push_exp(8'h20, 2);
        kick(8'h20, 9'd2);
        wait_done(30, 8'h41);

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rom_burst_reader.md
Name: rom_burst_reader

Overview:
Initiator for the synchronous ROM read interface (ce/ren/addr in, data out one cycle later). On a start command it sweeps a contiguous address range, issues one ROM read per cycle while buffer credit is available, and buffers the returned bytes in a small FIFO. It presents the bytes on a valid/ready stream with a last flag and accumulates an 8-bit checksum. It sits between a ROM instance and any consumer that needs bulk table or ROM contents.

Parameters:
ADDR_W, 8, ROM address width
DATA_W, 8, ROM data width
FIFO_DEPTH, 4, output buffer entries; power of 2, minimum 2
ROM_LAT, 1, cycles from sampled ce&ren to valid rom_data; fixed at 1 in this revision

Ports:
clk  in  1  clock, all logic on rising edge
resetn  in  1  asynchronous active-low reset
start  in  1  one-cycle command strobe; honoured only in IDLE
start_addr  in  ADDR_W  first address of the burst
len  in  ADDR_W+1  number of bytes, 0..256
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle pulse at end of burst
rom_ce  out  1  ROM chip enable, registered
rom_ren  out  1  ROM read enable, registered; always equal to rom_ce
rom_addr  out  ADDR_W  ROM address, registered
rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after the read
out_valid  out  1  stream data valid
out_ready  in  1  stream consumer ready
out_data  out  DATA_W  stream byte
out_last  out  1  high with the final byte of the burst
checksum  out  DATA_W  sum mod 2^DATA_W of bytes transferred in the current or last burst

Behaviour:
- Reset, asynchronous: all outputs go to 0, FSM goes to IDLE, FIFO empties, counters clear, and checksum is 0. rom_ce drops immediately, and any read in flight is discarded.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE: start=1 latches start_addr and len, and clears checksum.
  - len=0: go to DONE, issue no ROM reads.
  - Otherwise: go to READ.
  - start in any other state is ignored.
- READ: each cycle, issue a read if issued < len and (fifo_count + outstanding) < FIFO_DEPTH.
  - Issuing a read sets rom_ce=rom_ren=1 and rom_addr=cur_addr on the next edge, then increments cur_addr.
  - Otherwise rom_ce=rom_ren=0 on that edge.
  - Address wraps from 2^ADDR_W-1 to 0.
  - When the last read issues, go to DRAIN.
- Capture: rom_data is written into the FIFO exactly ROM_LAT cycles after each issued read. No extra condition is needed, because credit guarantees space.
- FIFO: registered output. out_valid rises the cycle after the write. A transfer occurs when out_valid&out_ready. Simultaneous write and read on a full or empty FIFO are both legal and keep the count consistent.
- Latency: start accepted at edge T gives rom_ce high after T+1, data written at T+2, out_valid at T+3. With out_ready=1 the throughput is one byte per cycle.
- out_last is high with the byte whose transfer count equals len. out_data, out_valid and out_last hold stable while out_valid=1 and out_ready=0.
- checksum increments by out_data on every transfer.
- DRAIN: after the final transfer, go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
  - checksum holds its value until the next accepted start.
  - start during DONE is ignored.
- busy is 1 in READ and DRAIN only.
- Width rules: the issued and transferred counters are ADDR_W+1 bits wide, so len=256 is exact. The checksum adder truncates to DATA_W.

Decomposition:
- Package rom_if_pkg holds:
  - ADDR_W and DATA_W defaults
  - the FSM state enum (IDLE, READ, DRAIN, DONE)
  - ROM_LAT
- Sub-module rom_rd_fifo is a synchronous FIFO with registered output and parameter FIFO_DEPTH.
  - Ports: clk, resetn, wr_en, wr_data, rd_en, rd_data, count.
  - The top level holds the FSM, the credit logic, the ROM drive and the checksum.

Test Plan:
(The bench ROM is preloaded with mem[i]=i.)
1. start_addr=0x10, len=4, out_ready=1:
   - rom_addr 10,11,12,13 on 4 consecutive cycles.
   - out_data 10..13, out_last on 13.
   - done pulses one cycle later; checksum=0x46.
2. Wrap: start_addr=0xFE, len=4:
   - rom_addr FE,FF,00,01; out_data FE,FF,00,01.
   - checksum=0xFE.
3. Backpressure: start_addr=0, len=8, out_ready=0 for 12 cycles:
   - Exactly 4 reads issue, then rom_ce stays 0 and out_data holds 00.
   - After out_ready=1: bytes 0..7 arrive in order; checksum=0x1C.
4. Full sweep: start_addr=0x80, len=256, out_ready toggling 1/0 every cycle:
   - 256 transfers, out_last only on byte 0x7F.
   - checksum=0x80; no byte is lost or duplicated.
5. len=0: rom_ce never rises, done pulses, busy stays 0, checksum=0x00. A start pulse during a busy burst is ignored and the burst is unaffected.
6. Reset mid-burst: resetn=0 after 3 transfers of a len=16 burst:
   - rom_ce, out_valid, busy and checksum go to 0 immediately.
   - After release, start_addr=0x20, len=2 yields bytes 20,21 and checksum=0x41.
